triangle_scanner: RTL and testbench
===================================

Name: triangle_scanner

Overview:
Traversal controller that drives the combinational edge-function rasterizer from the issuing side. It accepts one triangle over a valid/ready handshake and computes its screen-clamped bounding box. It sweeps every pixel in the box one per cycle, presenting pixel coordinates and held vertices to the rasterizer. It captures the returned weights and emits only visible pixels as a backpressured fragment stream to the shading stage.

Parameters:
SCREEN_W, 640, horizontal resolution; pixel x range 0..SCREEN_W-1
SCREEN_H, 480, vertical resolution; pixel y range 0..SCREEN_H-1

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tri_valid  in  1  triangle offered
tri_ready  out  1  high only in IDLE
tri_ax/ay/bx/by/cx/cy  in  10 each  vertex coordinates, unsigned
tri_bz/cz  in  8 each  vertex depth-weights
rast_ax/ay/bx/by/cx/cy  out  10 each  latched vertices to rasterizer, stable for whole triangle
rast_bz/cz  out  8 each  latched depths to rasterizer
rast_x, rast_y  out  10 each  current pixel under test
rast_uw/vw/ww/aw  in  20 each  rasterizer weights for rast_x/rast_y (same cycle)
rast_visible  in  1  rasterizer inside-test for rast_x/rast_y
frag_valid  out  1  fragment available
frag_ready  in  1  downstream accepts
frag_x, frag_y  out  10 each  fragment pixel
frag_uw/vw/ww/aw  out  20 each  captured weights
done  out  1  one-cycle pulse: triangle fully scanned and last fragment accepted

Behaviour:
- Reset: state IDLE; frag_valid=0, done=0; all registered data outputs 0; tri_ready=1 (combinational from state). Reset mid-triangle abandons it; frag_valid=0 the next cycle and no done pulse.
- IDLE: on tri_valid&&tri_ready, latch all vertex fields, go to SETUP.
- SETUP (1 cycle): min_x/max_x/min_y/max_y = unsigned min/max of the three vertices. Clamp max_x to SCREEN_W-1 and max_y to SCREEN_H-1.
  - If min_x>max_x or min_y>max_y (fully off-screen): go to FLUSH with no pixels.
  - Otherwise set cur=(min_x,min_y) and go to SCAN.
- SCAN: rast_x=cur_x, rast_y=cur_y (registered).
  - The output slot is free when !frag_valid || frag_ready.
  - When the slot is free: evaluate the current pixel. If rast_visible, load frag_* with cur and rast_* weights and set frag_valid=1; else frag_valid<=0. Advance the cursor.
  - When the slot is not free: hold the cursor and all frag_* outputs stable.
  - Advance rule: if cur_x==max_x then cur_x=min_x and cur_y+1; else cur_x+1.
  - Advancing from (max_x,max_y) goes to FLUSH.
- FLUSH: wait until !frag_valid, or frag_valid&&frag_ready (frag_valid clears). Then pulse done for one cycle and return to IDLE.
- Throughput: 1 pixel/cycle with frag_ready held high. A pixel evaluated in cycle N appears on frag_* in cycle N+1.
- Ordering: fragments leave in raster order (y-major, x ascending), never dropped or duplicated under any frag_ready pattern.
- Degenerate triangle (rasterizer reports visible=0 everywhere, including area 0): full box is swept, zero fragments, done still pulses.
- Weights pass through unmodified. No arithmetic on weights in this block; only 10-bit unsigned compares and increments. The cursor never exceeds max, so no wrap-around.
- tri_valid is ignored outside IDLE.

Decomposition:
- Shared package raster_pkg holds:
  - SCREEN_W and SCREEN_H constants.
  - coord_t (10b), depth_t (8b), weight_t (20b).
  - A vertex struct {x,y,z}.
  - A fragment struct {x,y,uw,vw,ww,aw}.
  - A state enum {IDLE,SETUP,SCAN,FLUSH}.
- One natural sub-module: bbox_setup, a combinational min/max/clamp producing box bounds and an empty flag.
- The rasterizer stays outside this block and is wired beside it at the top level.

Test Plan:
- Right triangle a=(0,0) b=(3,0) c=(0,3), frag_ready=1, real rasterizer attached:
  - 16 pixels scanned in 16 consecutive cycles.
  - Exactly 10 fragments emitted, those with x+y<=3, in raster order.
  - done pulses once after the last fragment.
- Same triangle with frag_ready toggling 1,0,1,0…:
  - Identical 10 fragments in identical order.
  - frag_* stable while frag_valid&&!frag_ready.
  - tri_ready stays 0 until done.
- Clamp: a=(630,470) b=(700,470) c=(630,500):
  - Box is x 630..639, y 470..479; 100 pixels swept.
  - rast_x never >639, rast_y never >479.
- Off-screen: a=(700,10) b=(800,10) c=(700,50):
  - No SCAN cycles, zero fragments.
  - done within 3 cycles of acceptance; tri_ready=1 the cycle after done.
- Degenerate: a=b=c=(5,5):
  - One pixel swept, zero fragments, one done pulse.
- Reset asserted during SCAN with frag_valid=1:
  - Next cycle frag_valid=0, tri_ready=1, no done pulse.
  - A following triangle completes normally.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared types and screen limits for the triangle traversal path.
package raster_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic [9:0]  coord_t;
    typedef logic [7:0]  depth_t;
    typedef logic [19:0] weight_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
        depth_t z;
    } vertex_t;

    typedef struct packed {
        coord_t  x;
        coord_t  y;
        weight_t uw;
        weight_t vw;
        weight_t ww;
        weight_t aw;
    } fragment_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SCAN,
        FLUSH
    } state_t;

    function automatic coord_t min3(coord_t a, coord_t b, coord_t c);
        coord_t m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic coord_t max3(coord_t a, coord_t b, coord_t c);
        coord_t m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/triangle_scanner_if.sv
// Triangle intake, rasterizer side-channel and fragment stream of the scanner.
interface triangle_scanner_if;
    import raster_pkg::*;

    logic    tri_valid;
    logic    tri_ready;
    coord_t  tri_ax, tri_ay, tri_bx, tri_by, tri_cx, tri_cy;
    depth_t  tri_bz, tri_cz;

    coord_t  rast_ax, rast_ay, rast_bx, rast_by, rast_cx, rast_cy;
    depth_t  rast_bz, rast_cz;
    coord_t  rast_x, rast_y;
    weight_t rast_uw, rast_vw, rast_ww, rast_aw;
    logic    rast_visible;

    logic    frag_valid;
    logic    frag_ready;
    coord_t  frag_x, frag_y;
    weight_t frag_uw, frag_vw, frag_ww, frag_aw;
    logic    done;

    modport slave (
        input  tri_valid, tri_ax, tri_ay, tri_bx, tri_by, tri_cx, tri_cy, tri_bz, tri_cz,
        output tri_ready,
        output rast_ax, rast_ay, rast_bx, rast_by, rast_cx, rast_cy, rast_bz, rast_cz,
        output rast_x, rast_y,
        input  rast_uw, rast_vw, rast_ww, rast_aw, rast_visible,
        output frag_valid, frag_x, frag_y, frag_uw, frag_vw, frag_ww, frag_aw, done,
        input  frag_ready
    );

    modport master (
        output tri_valid, tri_ax, tri_ay, tri_bx, tri_by, tri_cx, tri_cy, tri_bz, tri_cz,
        input  tri_ready,
        input  rast_ax, rast_ay, rast_bx, rast_by, rast_cx, rast_cy, rast_bz, rast_cz,
        input  rast_x, rast_y,
        output rast_uw, rast_vw, rast_ww, rast_aw, rast_visible,
        input  frag_valid, frag_x, frag_y, frag_uw, frag_vw, frag_ww, frag_aw, done,
        output frag_ready
    );

endinterface

// File: rtl/bbox_setup.sv
// Screen-clamped bounding box of a latched triangle; empty when fully off-screen.
module bbox_setup
    import raster_pkg::*;
(
    input  coord_t i_ax,
    input  coord_t i_ay,
    input  coord_t i_bx,
    input  coord_t i_by,
    input  coord_t i_cx,
    input  coord_t i_cy,
    output coord_t o_min_x,
    output coord_t o_max_x,
    output coord_t o_min_y,
    output coord_t o_max_y,
    output logic   o_empty
);

    localparam coord_t LAST_X = coord_t'(SCREEN_W - 1);
    localparam coord_t LAST_Y = coord_t'(SCREEN_H - 1);

    coord_t w_raw_max_x;
    coord_t w_raw_max_y;

    assign o_min_x     = min3(i_ax, i_bx, i_cx);
    assign o_min_y     = min3(i_ay, i_by, i_cy);
    assign w_raw_max_x = max3(i_ax, i_bx, i_cx);
    assign w_raw_max_y = max3(i_ay, i_by, i_cy);

    // Only the upper edge needs clamping; minima above the screen fall out as empty.
    assign o_max_x = (w_raw_max_x > LAST_X) ? LAST_X : w_raw_max_x;
    assign o_max_y = (w_raw_max_y > LAST_Y) ? LAST_Y : w_raw_max_y;
    assign o_empty = (o_min_x > o_max_x) || (o_min_y > o_max_y);

endmodule

// File: rtl/triangle_scanner.sv
// Sweeps a triangle's bounding box one pixel per cycle and streams visible fragments.
//  state | meaning
//  IDLE  | waiting for a triangle, tri_ready high
//  SETUP | box computed from latched vertices, pick first pixel or skip
//  SCAN  | one pixel per free output slot, raster order
//  FLUSH | drain last fragment, then pulse done
module triangle_scanner
    import raster_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    triangle_scanner_if.slave bus
);

    state_t    r_state;
    vertex_t   r_va, r_vb, r_vc;
    coord_t    r_cur_x, r_cur_y;
    fragment_t r_frag;
    logic      r_frag_valid;
    logic      r_done;

    coord_t    w_min_x, w_max_x, w_min_y, w_max_y;
    logic      w_empty;
    logic      w_slot_free;

    bbox_setup u_bbox (
        .i_ax    (r_va.x),
        .i_ay    (r_va.y),
        .i_bx    (r_vb.x),
        .i_by    (r_vb.y),
        .i_cx    (r_vc.x),
        .i_cy    (r_vc.y),
        .o_min_x (w_min_x),
        .o_max_x (w_max_x),
        .o_min_y (w_min_y),
        .o_max_y (w_max_y),
        .o_empty (w_empty)
    );

    assign w_slot_free = !r_frag_valid || bus.frag_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_va         <= '0;
            r_vb         <= '0;
            r_vc         <= '0;
            r_cur_x      <= '0;
            r_cur_y      <= '0;
            r_frag       <= '0;
            r_frag_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.tri_valid) begin
                        r_va    <= '{x: bus.tri_ax, y: bus.tri_ay, z: '0};
                        r_vb    <= '{x: bus.tri_bx, y: bus.tri_by, z: bus.tri_bz};
                        r_vc    <= '{x: bus.tri_cx, y: bus.tri_cy, z: bus.tri_cz};
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_empty) begin
                        r_state <= FLUSH;
                    end else begin
                        r_cur_x <= w_min_x;
                        r_cur_y <= w_min_y;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    // A stalled slot freezes both the cursor and the fragment outputs.
                    if (w_slot_free) begin
                        r_frag_valid <= bus.rast_visible;
                        if (bus.rast_visible) begin
                            r_frag <= '{x: r_cur_x, y: r_cur_y,
                                        uw: bus.rast_uw, vw: bus.rast_vw,
                                        ww: bus.rast_ww, aw: bus.rast_aw};
                        end
                        if (r_cur_x == w_max_x) begin
                            if (r_cur_y == w_max_y) begin
                                r_state <= FLUSH;
                            end else begin
                                r_cur_x <= w_min_x;
                                r_cur_y <= r_cur_y + 10'd1;
                            end
                        end else begin
                            r_cur_x <= r_cur_x + 10'd1;
                        end
                    end
                end
                FLUSH: begin
                    if (w_slot_free) begin
                        r_frag_valid <= 1'b0;
                        r_done       <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.tri_ready  = (r_state == IDLE);
    assign bus.rast_ax    = r_va.x;
    assign bus.rast_ay    = r_va.y;
    assign bus.rast_bx    = r_vb.x;
    assign bus.rast_by    = r_vb.y;
    assign bus.rast_cx    = r_vc.x;
    assign bus.rast_cy    = r_vc.y;
    assign bus.rast_bz    = r_vb.z;
    assign bus.rast_cz    = r_vc.z;
    assign bus.rast_x     = r_cur_x;
    assign bus.rast_y     = r_cur_y;
    assign bus.frag_valid = r_frag_valid;
    assign bus.frag_x     = r_frag.x;
    assign bus.frag_y     = r_frag.y;
    assign bus.frag_uw    = r_frag.uw;
    assign bus.frag_vw    = r_frag.vw;
    assign bus.frag_ww    = r_frag.ww;
    assign bus.frag_aw    = r_frag.aw;
    assign bus.done       = r_done;

endmodule

// File: tb/tb_triangle_scanner.sv
// Scanner bench: edge-function rasterizer beside the DUT, queue of expected fragments.
module tb_triangle_scanner;
    import raster_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad = 0;
    int   ready_mode = 0;
    int   n_rx = 0;
    int   n_exp = 0;
    logic [99:0] exp_q[$];
    logic [99:0] prev_frag = '0;
    logic        prev_stall = 1'b0;

    triangle_scanner_if u_if();

    triangle_scanner u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [100:0] got, input logic [100:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int edge_f(int ax, int ay, int bx, int by, int px, int py);
        return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
    endfunction

    // {visible, x, y, uw, vw, ww, aw}
    function automatic logic [100:0] eval_px(int ax, int ay, int bx, int by, int cx, int cy,
                                             int bz, int cz, int px, int py);
        int area, e_ab, e_bc, e_ca, aw;
        logic vis;
        area = edge_f(ax, ay, bx, by, cx, cy);
        e_ab = edge_f(ax, ay, bx, by, px, py);
        e_bc = edge_f(bx, by, cx, cy, px, py);
        e_ca = edge_f(cx, cy, ax, ay, px, py);
        vis  = (area > 0 && e_ab >= 0 && e_bc >= 0 && e_ca >= 0) ||
               (area < 0 && e_ab <= 0 && e_bc <= 0 && e_ca <= 0);
        aw   = area + bz + cz;
        return {vis, px[9:0], py[9:0], e_bc[19:0], e_ca[19:0], e_ab[19:0], aw[19:0]};
    endfunction

    always_comb begin
        logic [100:0] r;
        r = eval_px(int'(u_if.rast_ax), int'(u_if.rast_ay), int'(u_if.rast_bx), int'(u_if.rast_by),
                    int'(u_if.rast_cx), int'(u_if.rast_cy), int'(u_if.rast_bz), int'(u_if.rast_cz),
                    int'(u_if.rast_x), int'(u_if.rast_y));
        u_if.rast_visible = r[100];
        u_if.rast_uw      = r[79:60];
        u_if.rast_vw      = r[59:40];
        u_if.rast_ww      = r[39:20];
        u_if.rast_aw      = r[19:0];
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       u_if.frag_ready = 1'b1;
            1:       u_if.frag_ready = (u_if.frag_ready === 1'b1) ? 1'b0 : 1'b1;
            2:       u_if.frag_ready = ($urandom_range(0, 3) != 0);
            default: u_if.frag_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        logic [99:0] cur;
        cur = {u_if.frag_x, u_if.frag_y, u_if.frag_uw, u_if.frag_vw, u_if.frag_ww, u_if.frag_aw};
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("frag_hold", {u_if.frag_valid, cur}, {1'b1, prev_frag});
            if (u_if.frag_valid && u_if.frag_ready) begin
                n_rx++;
                if (exp_q.size() > 0)
                    chk("frag_data", 101'(cur), 101'(exp_q.pop_front()));
            end
            if (!u_if.tri_ready) begin
                chk("rast_x_max", 101'(u_if.rast_x <= 10'(SCREEN_W - 1)), 101'(1));
                chk("rast_y_max", 101'(u_if.rast_y <= 10'(SCREEN_H - 1)), 101'(1));
            end
            prev_stall = u_if.frag_valid && !u_if.frag_ready;
            prev_frag  = cur;
        end
    end

    task automatic drive_tri(input int ax, input int ay, input int bx, input int by,
                             input int cx, input int cy, input int bz, input int cz);
        @(negedge clk);
        u_if.tri_ax = 10'(ax); u_if.tri_ay = 10'(ay);
        u_if.tri_bx = 10'(bx); u_if.tri_by = 10'(by);
        u_if.tri_cx = 10'(cx); u_if.tri_cy = 10'(cy);
        u_if.tri_bz = 8'(bz);  u_if.tri_cz = 8'(cz);
        u_if.tri_valid = 1'b1;
        @(posedge clk);
        #1 u_if.tri_valid = 1'b0;
    endtask

    task automatic run_tri(input int ax, input int ay, input int bx, input int by,
                           input int cx, input int cy, input int bz, input int cz,
                           input int mode, input bit check_timing);
        int minx, maxx, miny, maxy, npx, busy;
        bit early_ready, seen;
        logic [100:0] r;
        exp_q.delete();
        n_rx = 0;
        minx = (ax < bx) ? ((ax < cx) ? ax : cx) : ((bx < cx) ? bx : cx);
        miny = (ay < by) ? ((ay < cy) ? ay : cy) : ((by < cy) ? by : cy);
        maxx = (ax > bx) ? ((ax > cx) ? ax : cx) : ((bx > cx) ? bx : cx);
        maxy = (ay > by) ? ((ay > cy) ? ay : cy) : ((by > cy) ? by : cy);
        if (maxx > SCREEN_W - 1) maxx = SCREEN_W - 1;
        if (maxy > SCREEN_H - 1) maxy = SCREEN_H - 1;
        npx = 0;
        for (int y = miny; y <= maxy; y++)
            for (int x = minx; x <= maxx; x++) begin
                npx++;
                r = eval_px(ax, ay, bx, by, cx, cy, bz, cz, x, y);
                if (r[100]) exp_q.push_back(r[99:0]);
            end
        n_exp = exp_q.size();
        ready_mode = mode;
        drive_tri(ax, ay, bx, by, cx, cy, bz, cz);
        busy = 0; early_ready = 0; seen = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (u_if.done) begin
                seen = 1;
                break;
            end
            busy++;
            if (u_if.tri_ready) early_ready = 1;
        end
        chk("done_seen", 101'(seen), 101'(1));
        chk("tri_ready_busy", 101'(early_ready), 101'(0));
        if (check_timing) chk("busy_cycles", 101'(busy), 101'(npx + 2));
        chk("frag_count", 101'(n_rx), 101'(n_exp));
        @(negedge clk);
        chk("done_single", 101'(u_if.done), 101'(0));
        chk("tri_ready_after", 101'(u_if.tri_ready), 101'(1));
    endtask

    initial begin
        bit seen_fv;
        int bx0, by0;
        u_if.tri_valid = 1'b0;
        u_if.tri_ax = '0; u_if.tri_ay = '0; u_if.tri_bx = '0;
        u_if.tri_by = '0; u_if.tri_cx = '0; u_if.tri_cy = '0;
        u_if.tri_bz = '0; u_if.tri_cz = '0;
        ready_mode = 0;
        repeat (3) @(negedge clk);
        chk("rst_tri_ready", 101'(u_if.tri_ready), 101'(1));
        chk("rst_frag_valid", 101'(u_if.frag_valid), 101'(0));
        chk("rst_done", 101'(u_if.done), 101'(0));
        chk("rst_rast_xy", 101'({u_if.rast_x, u_if.rast_y}), 101'(0));
        chk("rst_frag_xy", 101'({u_if.frag_x, u_if.frag_y, u_if.frag_aw}), 101'(0));
        rst = 1'b0;

        run_tri(0, 0, 3, 0, 0, 3, 7, 9, 0, 1);
        chk("right_tri_frags", 101'(n_rx), 101'(10));
        run_tri(0, 0, 3, 0, 0, 3, 7, 9, 1, 0);
        chk("right_tri_toggle", 101'(n_rx), 101'(10));
        run_tri(630, 470, 700, 470, 630, 500, 1, 2, 0, 1);
        run_tri(700, 10, 800, 10, 700, 50, 3, 4, 0, 1);
        chk("offscreen_frags", 101'(n_rx), 101'(0));
        run_tri(5, 5, 5, 5, 5, 5, 0, 0, 0, 1);
        chk("degenerate_frags", 101'(n_rx), 101'(0));

        // Abandon a triangle mid-scan with a stalled fragment on the output.
        ready_mode = 3;
        drive_tri(0, 0, 3, 0, 0, 3, 7, 9);
        seen_fv = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (u_if.frag_valid) begin
                seen_fv = 1;
                break;
            end
        end
        chk("rst_mid_pre_valid", 101'(seen_fv), 101'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_frag_valid", 101'(u_if.frag_valid), 101'(0));
        chk("rst_mid_tri_ready", 101'(u_if.tri_ready), 101'(1));
        chk("rst_mid_done", 101'(u_if.done), 101'(0));
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        ready_mode = 0;
        @(negedge clk);
        chk("rst_mid_no_done", 101'(u_if.done), 101'(0));
        run_tri(0, 0, 3, 0, 0, 3, 7, 9, 2, 0);
        chk("after_rst_frags", 101'(n_rx), 101'(10));

        for (int t = 0; t < 24; t++) begin
            bx0 = $urandom_range(0, 700);
            by0 = $urandom_range(0, 500);
            run_tri(bx0 + $urandom_range(0, 15), by0 + $urandom_range(0, 15),
                    bx0 + $urandom_range(0, 15), by0 + $urandom_range(0, 15),
                    bx0 + $urandom_range(0, 15), by0 + $urandom_range(0, 15),
                    $urandom_range(0, 255), $urandom_range(0, 255),
                    (t % 3 == 0) ? 0 : 2, (t % 3 == 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
